// File: rtl/e32_config_controller.sv
// E32 config-mode sequencer: parses C0..C4 frames, updates cfg/saved regs, streams replies (WRITE_ECHO_EN echoes C0/C2).
// Latency: EXEC the cycle after the final byte; replies stall indefinitely on i_tx_ready; aux_busy spans EXEC..hold end.
module e32_config_controller #(
  parameter int unsigned END_PROCESS_COMMAND = 6250,
  parameter int unsigned END_PROCESS_RESET   = 12500,
  parameter int unsigned BYTE_TIMEOUT        = 960,
  parameter logic [7:0]  DEFAULT_ADDH        = 8'h00,
  parameter logic [7:0]  DEFAULT_ADDL        = 8'h00,
  parameter logic [7:0]  DEFAULT_SPED        = 8'h1A,
  parameter logic [7:0]  DEFAULT_CHAN        = 8'h17,
  parameter logic [7:0]  DEFAULT_OPTION      = 8'h44,
  parameter logic [7:0]  VERSION_B1          = 8'h32,
  parameter logic [7:0]  VERSION_B2          = 8'h0D,
  parameter logic [7:0]  VERSION_B3          = 8'h14
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mode_en,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic [7:0] o_cfg_addh,
  output logic [7:0] o_cfg_addl,
  output logic [7:0] o_cfg_sped,
  output logic [7:0] o_cfg_chan,
  output logic [7:0] o_cfg_option,
  output logic       o_reset_req,
  output logic       o_aux_busy,
  output logic       o_cmd_error
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COLLECT  = 3'd1;
  localparam logic [2:0] ST_EXEC     = 3'd2;
  localparam logic [2:0] ST_RESPOND  = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_RST_HOLD = 3'd5;

  localparam int unsigned HOLD_MAX = (END_PROCESS_RESET > END_PROCESS_COMMAND) ?
                                     END_PROCESS_RESET : END_PROCESS_COMMAND;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [HW-1:0] CMD_LAST  = HW'(END_PROCESS_COMMAND - 1);
  localparam logic [HW-1:0] RST_LAST  = HW'(END_PROCESS_RESET - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(BYTE_TIMEOUT);
  localparam logic [39:0]   DEFAULTS  = {DEFAULT_ADDH, DEFAULT_ADDL, DEFAULT_SPED,
                                         DEFAULT_CHAN, DEFAULT_OPTION};

  // Parameter blocks packed ADDH..OPTION, MSB first, matching wire order.
  logic [2:0]    r_state;
  logic [7:0]    r_hdr;
  logic [39:0]   r_pay;
  logic [39:0]   r_act;
  logic [39:0]   r_sav;
  logic [2:0]    r_cnt;
  logic [TW-1:0] r_tmo;
  logic [HW-1:0] r_hold;
  logic [39:0]   r_buf;
  logic [2:0]    r_left;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_reset_req;
  logic          r_busy;
  logic          r_err;

  logic w_is_write;
  logic w_last_byte;
  logic w_stray_byte;

  assign w_is_write   = (r_hdr == 8'hC0) || (r_hdr == 8'hC2);
  assign w_last_byte  = w_is_write ? (r_cnt == 3'd4) : (r_cnt == 3'd1);
  assign w_stray_byte = i_rx_valid && (r_state != ST_IDLE) && (r_state != ST_COLLECT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_hdr       <= 8'h00;
      r_pay       <= 40'h0;
      r_act       <= DEFAULTS;
      r_sav       <= DEFAULTS;
      r_cnt       <= 3'd0;
      r_tmo       <= '0;
      r_hold      <= '0;
      r_buf       <= 40'h0;
      r_left      <= 3'd0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_reset_req <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err       <= w_stray_byte;
      r_reset_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_rx_valid && i_mode_en) begin
            r_hdr <= i_rx_data;
            r_cnt <= 3'd0;
            r_tmo <= '0;
            case (i_rx_data)
              8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4: r_state <= ST_COLLECT;
              default:                           r_err   <= 1'b1;
            endcase
          end
        end
        ST_COLLECT: begin
          // Abort and timeout take priority over a byte arriving in the same cycle.
          if (!i_mode_en || (r_tmo == TMO_LIMIT)) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (i_rx_valid) begin
            r_tmo <= '0;
            if (!w_is_write && (i_rx_data != r_hdr)) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_pay <= {r_pay[31:0], i_rx_data};
              r_cnt <= r_cnt + 3'd1;
              if (w_last_byte) begin
                r_state <= ST_EXEC;
                r_busy  <= 1'b1;
              end
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_EXEC: begin
          r_hold  <= '0;
          r_state <= ST_HOLD;
          case (r_hdr)
            8'hC0, 8'hC2: begin
              r_act <= r_pay;
              if (r_hdr == 8'hC0) r_sav <= r_pay;
`ifdef WRITE_ECHO_EN
              r_tx_data  <= r_hdr;
              r_buf      <= r_pay;
              r_left     <= 3'd5;
              r_tx_valid <= 1'b1;
              r_state    <= ST_RESPOND;
`endif
            end
            8'hC1: begin
              r_tx_data  <= 8'hC0;
              r_buf      <= r_sav;
              r_left     <= 3'd5;
              r_tx_valid <= 1'b1;
              r_state    <= ST_RESPOND;
            end
            8'hC3: begin
              r_tx_data  <= 8'hC3;
              r_buf      <= {VERSION_B1, VERSION_B2, VERSION_B3, 16'h0000};
              r_left     <= 3'd3;
              r_tx_valid <= 1'b1;
              r_state    <= ST_RESPOND;
            end
            default: begin
              r_act       <= r_sav;
              r_reset_req <= 1'b1;
              r_state     <= ST_RST_HOLD;
            end
          endcase
        end
        ST_RESPOND: begin
          if (r_tx_valid && i_tx_ready) begin
            if (r_left == 3'd0) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_state    <= ST_HOLD;
            end else begin
              r_tx_data <= r_buf[39:32];
              r_buf     <= {r_buf[31:0], 8'h00};
              r_left    <= r_left - 3'd1;
            end
          end
        end
        ST_HOLD: begin
          if (r_hold == CMD_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ST_RST_HOLD: begin
          if (r_hold == RST_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_tx_valid   = r_tx_valid;
  assign o_cfg_addh   = r_act[39:32];
  assign o_cfg_addl   = r_act[31:24];
  assign o_cfg_sped   = r_act[23:16];
  assign o_cfg_chan   = r_act[15:8];
  assign o_cfg_option = r_act[7:0];
  assign o_reset_req  = r_reset_req;
  assign o_aux_busy   = r_busy;
  assign o_cmd_error  = r_err;

endmodule
